// File: rtl/pi_bus_sync_if.sv
// Bundle of Pi pad-side and register-file-side signals for pi_bus_sync.
// The slave modport is the sync stage; the master modport is whatever drives the Pi pins and answers reads.
interface pi_bus_sync_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              pi_clk;
    logic              pi_rw;
    logic [ADDR_W-1:0] pi_addr;
    logic [DATA_W-1:0] pi_data_i;
    logic [DATA_W-1:0] pi_data_o;
    logic              pi_data_oe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              overrun;
    logic [15:0]       txn_count;

    modport slave (
        input  pi_clk, pi_rw, pi_addr, pi_data_i, rd_data,
        output pi_data_o, pi_data_oe, wr_en, wr_addr, wr_data,
        output rd_en, rd_addr, overrun, txn_count
    );

    modport master (
        output pi_clk, pi_rw, pi_addr, pi_data_i, rd_data,
        input  pi_data_o, pi_data_oe, wr_en, wr_addr, wr_data,
        input  rd_en, rd_addr, overrun, txn_count
    );
endinterface

// File: rtl/pi_bus_sync.sv
// Pi parallel-bus front end: synchronises the async Pi pins, turns each strobe rise into one
// register-file request and returns read data. Optional PI_BUS_GLITCH_FILTER_EN qualifies strobes.
module pi_bus_sync #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    pi_bus_sync_if.slave bus
);
    localparam int SYNC_W = 2 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_CAP
    } state_t;

    // Synchroniser chain, all Pi inputs packed as {clk, rw, addr, data}
    logic [SYNC_W-1:0] sync_raw;
    logic [SYNC_W-1:0] s1_q, s1_d;
    logic [SYNC_W-1:0] s2_q, s2_d;
    logic              s3_clk_q, s3_clk_d;

    logic              s2_clk;
    logic              s2_rw;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data;

    logic [1:0]        fill_q, fill_d;
    logic              armed_q, armed_d;
    logic              raw_edge;
    logic              edge_acc;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] pi_data_o_q, pi_data_o_d;
    logic              pi_data_oe_q, pi_data_oe_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       txn_count_q, txn_count_d;

    assign sync_raw = {bus.pi_clk, bus.pi_rw, bus.pi_addr, bus.pi_data_i};

    generate
        for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_sync
            assign s1_d[gi] = sync_raw[gi];
            assign s2_d[gi] = s1_q[gi];
        end
    endgenerate

    assign s2_clk  = s2_q[SYNC_W-1];
    assign s2_rw   = s2_q[SYNC_W-2];
    assign s2_addr = s2_q[DATA_W +: ADDR_W];
    assign s2_data = s2_q[0 +: DATA_W];

    // The chain holds reset zeros for two cycles, so a low s2 only counts once it is a real sample;
    // otherwise a strobe already high at reset release would look like a fresh rise.
    always_comb begin
        s3_clk_d = s2_clk;
        fill_d   = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
        armed_d  = armed_q | ((fill_q == 2'd2) & ~s2_clk);
        raw_edge = s2_clk & ~s3_clk_q & armed_q;
    end

`ifdef PI_BUS_GLITCH_FILTER_EN
    logic [1:0] glt_cnt_q, glt_cnt_d;

    // Rise is accepted only after s2_clk stays high for two more cycles; a drop cancels it quietly.
    always_comb begin
        glt_cnt_d = 2'd0;
        edge_acc  = 1'b0;
        if (raw_edge) begin
            glt_cnt_d = 2'd1;
        end else if ((glt_cnt_q != 2'd0) && s2_clk) begin
            if (glt_cnt_q == 2'd2) begin
                edge_acc = 1'b1;
            end else begin
                glt_cnt_d = glt_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glt_cnt_q <= 2'd0;
        end else begin
            glt_cnt_q <= glt_cnt_d;
        end
    end
`else
    assign edge_acc = raw_edge;
`endif

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        pi_data_o_d  = pi_data_o_q;
        pi_data_oe_d = s2_rw;
        txn_count_d  = txn_count_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (edge_acc) begin
                    if (s2_rw) begin
                        state_d   = ST_RD;
                        rd_en_d   = 1'b1;
                        rd_addr_d = s2_addr;
                    end else begin
                        state_d   = ST_WR;
                        wr_en_d   = 1'b1;
                        wr_addr_d = s2_addr;
                        wr_data_d = s2_data;
                    end
                end
            end
            ST_WR: begin
                txn_count_d = txn_count_q + 16'd1;
                state_d     = ST_IDLE;
            end
            ST_RD: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                pi_data_o_d = bus.rd_data;
                txn_count_d = txn_count_q + 16'd1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe landing mid-transaction is dropped; only the sticky flag records it.
        if (edge_acc && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_clk_q     <= 1'b0;
            fill_q       <= 2'd0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            pi_data_o_q  <= '0;
            pi_data_oe_q <= 1'b0;
            overrun_q    <= 1'b0;
            txn_count_q  <= 16'd0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_clk_q     <= s3_clk_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pi_data_o_q  <= pi_data_o_d;
            pi_data_oe_q <= pi_data_oe_d;
            overrun_q    <= overrun_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.pi_data_o  = pi_data_o_q;
    assign bus.pi_data_oe = pi_data_oe_q;
    assign bus.overrun    = overrun_q;
    assign bus.txn_count  = txn_count_q;
endmodule

// File: tb/tb_pi_bus_sync.sv
// Directed bench for pi_bus_sync: writes, reads, output enable, overrun, reset re-arm and count wrap.
// Inputs change and outputs are checked on the falling clock edge.
module tb_pi_bus_sync;
`ifdef PI_BUS_GLITCH_FILTER_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   both_hi   = 0;
    int   wr_base;
    int   rd_base;
    int   exp_txn;

    always #5 clk = ~clk;

    pi_bus_sync_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    pi_bus_sync #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] rd_model(input logic [5:0] a);
        if (a == 6'h05) return 8'h3C;
        return {2'b00, a} ^ 8'h5A;
    endfunction

    // Register-file stand-in: data valid exactly one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? rd_model(bus.rd_addr) : 8'hEE;
        if (bus.wr_en) wr_pulses <= wr_pulses + 1;
        if (bus.rd_en) rd_pulses <= rd_pulses + 1;
        if (bus.wr_en && bus.rd_en) both_hi <= both_hi + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst           = 1'b1;
        bus.pi_clk    = 1'b0;
        bus.pi_rw     = 1'b0;
        bus.pi_addr   = 6'h00;
        bus.pi_data_i = 8'h00;
        exp_txn       = 0;
        tick(3);
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_rd_en", 32'(bus.rd_en), 32'h0);
        chk("rst_data_o", 32'(bus.pi_data_o), 32'h00);
        chk("rst_oe", 32'(bus.pi_data_oe), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        chk("rst_txn", 32'(bus.txn_count), 32'h0);
        rst = 1'b0;
        tick(4);

        // Write 0x05 <- 0xA5
        bus.pi_rw = 1'b0; bus.pi_addr = 6'h05; bus.pi_data_i = 8'hA5;
        tick(2);
        wr_base = wr_pulses;
        bus.pi_clk = 1'b1;
        tick(2 + LAT);
        chk("wr_not_early", 32'(bus.wr_en), 32'h0);
        tick(1);
        chk("wr_en", 32'(bus.wr_en), 32'h1);
        chk("wr_addr", 32'(bus.wr_addr), 32'h05);
        chk("wr_data", 32'(bus.wr_data), 32'hA5);
        chk("wr_no_rd", 32'(bus.rd_en), 32'h0);
        tick(1);
        exp_txn++;
        chk("wr_en_drop", 32'(bus.wr_en), 32'h0);
        chk("wr_txn", 32'(bus.txn_count), 32'(exp_txn));
        bus.pi_clk = 1'b0;
        tick(3);
        chk("wr_single_pulse", 32'(wr_pulses - wr_base), 32'h1);

        // Read 0x05 -> 0x3C, output enable follows rw after three edges
        bus.pi_rw = 1'b1;
        tick(2);
        chk("oe_lag", 32'(bus.pi_data_oe), 32'h0);
        tick(1);
        chk("oe_high", 32'(bus.pi_data_oe), 32'h1);
        rd_base = rd_pulses;
        bus.pi_clk = 1'b1;
        tick(3 + LAT);
        chk("rd_en", 32'(bus.rd_en), 32'h1);
        chk("rd_addr", 32'(bus.rd_addr), 32'h05);
        chk("rd_no_wr", 32'(bus.wr_en), 32'h0);
        tick(1);
        chk("rd_data_o_old", 32'(bus.pi_data_o), 32'h00);
        tick(1);
        exp_txn++;
        chk("rd_data_o", 32'(bus.pi_data_o), 32'h3C);
        chk("rd_txn", 32'(bus.txn_count), 32'(exp_txn));
        bus.pi_clk = 1'b0;
        tick(3);
        chk("rd_single_pulse", 32'(rd_pulses - rd_base), 32'h1);

        // Read lowest address 0x00 -> 0x5A
        bus.pi_addr = 6'h00;
        tick(2);
        bus.pi_clk = 1'b1;
        tick(5 + LAT);
        exp_txn++;
        chk("rd0_data_o", 32'(bus.pi_data_o), 32'h5A);
        chk("rd0_txn", 32'(bus.txn_count), 32'(exp_txn));
        bus.pi_clk = 1'b0;
        tick(3);

        // Write top address 0x3F <- 0x5A; read data must hold
        bus.pi_rw = 1'b0; bus.pi_addr = 6'h3F; bus.pi_data_i = 8'h5A;
        tick(3);
        bus.pi_clk = 1'b1;
        tick(3 + LAT);
        chk("wr3f_en", 32'(bus.wr_en), 32'h1);
        chk("wr3f_addr", 32'(bus.wr_addr), 32'h3F);
        chk("wr3f_data", 32'(bus.wr_data), 32'h5A);
        tick(1);
        exp_txn++;
        chk("wr3f_txn", 32'(bus.txn_count), 32'(exp_txn));
        chk("hold_data_o", 32'(bus.pi_data_o), 32'h5A);
        chk("oe_low", 32'(bus.pi_data_oe), 32'h0);
        bus.pi_clk = 1'b0;
        tick(3);

`ifndef PI_BUS_GLITCH_FILTER_EN
        // Two strobe rises 2 clk apart during a read: second is dropped
        bus.pi_rw = 1'b1; bus.pi_addr = 6'h12;
        tick(3);
        rd_base = rd_pulses;
        bus.pi_clk = 1'b1; tick(1);
        bus.pi_clk = 1'b0; tick(1);
        bus.pi_clk = 1'b1; tick(2);
        bus.pi_clk = 1'b0; tick(8);
        exp_txn++;
        chk("ovr_one_rd", 32'(rd_pulses - rd_base), 32'h1);
        chk("ovr_flag", 32'(bus.overrun), 32'h1);
        chk("ovr_txn", 32'(bus.txn_count), 32'(exp_txn));
        chk("ovr_data_o", 32'(bus.pi_data_o), 32'h48);
`else
        // Two-cycle strobe is filtered out entirely
        bus.pi_rw = 1'b0; bus.pi_addr = 6'h2A; bus.pi_data_i = 8'hC3;
        tick(3);
        wr_base = wr_pulses;
        bus.pi_clk = 1'b1; tick(2);
        bus.pi_clk = 1'b0; tick(8);
        chk("glt_no_wr", 32'(wr_pulses - wr_base), 32'h0);
        chk("glt_no_overrun", 32'(bus.overrun), 32'h0);
        chk("glt_txn", 32'(bus.txn_count), 32'(exp_txn));
`endif

        // Normal write afterwards; overrun state is unchanged
        bus.pi_rw = 1'b0; bus.pi_addr = 6'h2A; bus.pi_data_i = 8'hC3;
        tick(3);
        bus.pi_clk = 1'b1;
        tick(3 + LAT);
        chk("wr2a_addr", 32'(bus.wr_addr), 32'h2A);
        chk("wr2a_data", 32'(bus.wr_data), 32'hC3);
        tick(1);
        exp_txn++;
        chk("wr2a_txn", 32'(bus.txn_count), 32'(exp_txn));
`ifndef PI_BUS_GLITCH_FILTER_EN
        chk("ovr_sticky", 32'(bus.overrun), 32'h1);
`endif
        bus.pi_clk = 1'b0;
        tick(3);

        // Reset mid-write with strobe held high: no request until strobe cycles low/high
        bus.pi_addr = 6'h21; bus.pi_data_i = 8'h77;
        tick(3);
        wr_base = wr_pulses;
        bus.pi_clk = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_overrun", 32'(bus.overrun), 32'h0);
        chk("mid_rst_txn", 32'(bus.txn_count), 32'h0);
        rst = 1'b0;
        tick(8);
        chk("rst_high_no_wr", 32'(wr_pulses - wr_base), 32'h0);
        chk("rst_high_data_o", 32'(bus.pi_data_o), 32'h00);
        bus.pi_clk = 1'b0;
        tick(3);
        bus.pi_clk = 1'b1;
        tick(3 + LAT);
        chk("rearm_wr_en", 32'(bus.wr_en), 32'h1);
        chk("rearm_wr_addr", 32'(bus.wr_addr), 32'h21);
        chk("rearm_wr_data", 32'(bus.wr_data), 32'h77);
        tick(1);
        chk("rearm_txn", 32'(bus.txn_count), 32'h1);
        bus.pi_clk = 1'b0;
        tick(3);

        // Count wrap 0xFFFF -> 0x0000
        force dut.txn_count_q = 16'hFFFF;
        tick(1);
        release dut.txn_count_q;
        chk("wrap_preload", 32'(bus.txn_count), 32'hFFFF);
        bus.pi_addr = 6'h01; bus.pi_data_i = 8'h00;
        tick(2);
        bus.pi_clk = 1'b1;
        tick(4 + LAT);
        chk("wrap_txn", 32'(bus.txn_count), 32'h0000);
        bus.pi_clk = 1'b0;
        tick(3);

        chk("never_both", 32'(both_hi), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
